mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have: CLK  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have: RESET  input  1  reset, synchronous, active-high.
REQ-003 SHALL have per port n in {0,1}: Pn_READ, Pn_WRITE  input  1  requester read/write request (0 = dcache, 1 = icache).
REQ-004 SHALL have: Pn_ADDRESS  input  6  block address; Pn_WRITEDATA  input  32  write block.
REQ-005 SHALL have: Pn_READDATA  output  32  registered read block; Pn_BUSYWAIT  output  1  stall to requester n.
REQ-006 SHALL have: MEM_READ, MEM_WRITE  output  1; MEM_ADDRESS  output  6; MEM_WRITEDATA  output  32; all registered.
REQ-007 SHALL have: MEM_READDATA  input  32; MEM_BUSYWAIT  input  1  from the data memory.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; grant register GNT (1 bit); flag SEEN_BUSY.
REQ-009 Request for port n SHALL be REQn = Pn_READ | Pn_WRITE; simultaneous Pn_READ and Pn_WRITE SHALL be treated as a write.
REQ-010 IDLE: if any REQn, at posedge SHALL set GNT to the winner, latch its address/writedata/op into MEM_* outputs, clear SEEN_BUSY, go ACCESS; else stay IDLE.
REQ-011 ACCESS: SHALL set SEEN_BUSY at any posedge where MEM_BUSYWAIT=1.
REQ-012 ACCESS completion = SEEN_BUSY=1 and MEM_BUSYWAIT=0 at posedge; SHALL then clear MEM_READ/MEM_WRITE, load PGNT_READDATA from MEM_READDATA (reads only), go RESP.
REQ-013 RESP SHALL last exactly one cycle, then go IDLE; no new grant SHALL be issued from RESP.
REQ-014 Pn_BUSYWAIT SHALL be combinational: REQn & ~(state==RESP & GNT==n).
REQ-015 Non-granted port SHALL hold Pn_BUSYWAIT=1 for as long as REQn=1.
REQ-016 Pn_READDATA SHALL hold its last value except at its own read completion.
REQ-017 Requester dropping REQn during ACCESS SHALL NOT abort the memory transaction; it completes, result discarded, FSM proceeds via RESP.
REQ-018 MEM_ADDRESS/MEM_WRITEDATA SHALL stay constant from grant until completion.
REQ-019 Minimum turnaround: request seen at posedge k, MEM_READ high from k; with memory busywait high for L cycles, RESP at k+L+1, IDLE at k+L+2.

Reset
REQ-020 RESET=1 at posedge SHALL force IDLE, GNT=0, SEEN_BUSY=0, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, P0_READDATA=P1_READDATA=0, round-robin pointer to favour port 0.
REQ-021 RESET mid-ACCESS SHALL abandon the transaction; no READDATA update; requesters still holding REQn re-arbitrate from IDLE.

Configuration
REQ-022 With ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL go to the port not granted last (pointer updated on each grant).
REQ-023 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always grant port 0 (dcache); no pointer register exists.

Structure
REQ-024 Shared package mem_arb_pkg SHALL hold state encoding (IDLE=0, ACCESS=1, RESP=2), port IDs (PORT_D=0, PORT_I=1), ADDR_W=6, DATA_W=32.
REQ-025 Winner selection SHALL be a sub-module arb_pick (inputs REQ0, REQ1, last grant; output winner, valid), holding the ARB_ROUND_ROBIN_EN variant.
REQ-026 Total RTL SHALL stay within 120-400 lines.

Verification (memory model: busywait high 5 cycles after request)
REQ-027 P0_READ, addr 6'h05, memory word 32'hDEADBEEF -> MEM_READ high 6 cycles, P0_READDATA=32'hDEADBEEF, P0_BUSYWAIT low exactly one cycle.
REQ-028 P0_WRITE addr 6'h0A data 32'h12345678 and P1_READ addr 6'h01 same cycle -> port 0 served first; P1_BUSYWAIT high throughout; port 1 granted on the cycle after RESP.
REQ-029 ARB_ROUND_ROBIN_EN: both ports requesting continuously -> grants alternate 0,1,0,1; without macro -> port 0 only while it requests.
REQ-030 P1_READ raised then dropped after 2 cycles of ACCESS -> MEM_READ held to completion, P1_READDATA unchanged, FSM returns IDLE.
REQ-031 RESET pulsed 3 cycles into ACCESS -> next posedge all MEM_* outputs 0, state IDLE, READDATA registers 0.
REQ-032 P0_READ and P0_WRITE both high, addr 6'h3F -> MEM_WRITE=1, MEM_READ=0, MEM_ADDRESS=6'h3F.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port identifiers and bus widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between the dcache (port 0) and icache (port 1) requests.
// Optional macro ARB_ROUND_ROBIN_EN: on a tie, pick the port not granted last;
// without it a tie always goes to the dcache.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST_GNT,
    output logic WINNER,
    output logic VALID
);

    // Combinational priority decision for the current request pair
    always_comb begin
        VALID  = REQ0 | REQ1;
        WINNER = PORT_D;
`ifdef ARB_ROUND_ROBIN_EN
        if (REQ0 & REQ1) begin
            WINNER = ~LAST_GNT;
        end else if (REQ1) begin
            WINNER = PORT_I;
        end
`else
        if (REQ1 & ~REQ0) begin
            WINNER = PORT_I;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_gnt;
    assign unused_last_gnt = LAST_GNT;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises dcache (port 0) and icache (port 1)
// block accesses onto a single data memory with a busywait handshake.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              P0_READ,
    input  logic              P0_WRITE,
    input  logic [ADDR_W-1:0] P0_ADDRESS,
    input  logic [DATA_W-1:0] P0_WRITEDATA,
    output logic [DATA_W-1:0] P0_READDATA,
    output logic              P0_BUSYWAIT,
    input  logic              P1_READ,
    input  logic              P1_WRITE,
    input  logic [ADDR_W-1:0] P1_ADDRESS,
    input  logic [DATA_W-1:0] P1_WRITEDATA,
    output logic [DATA_W-1:0] P1_READDATA,
    output logic              P1_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    arb_state_t        state;
    logic              gnt;
    logic              seen_busy;
    logic              req0;
    logic              req1;
    logic              gnt_req;
    logic              pick_winner;
    logic              pick_valid;
    logic              last_gnt;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req0    = P0_READ | P0_WRITE;
    assign req1    = P1_READ | P1_WRITE;
    assign gnt_req = (gnt == PORT_I) ? req1 : req0;

    assign P0_BUSYWAIT = req0 & ~((state == RESP) && (gnt == PORT_D));
    assign P1_BUSYWAIT = req1 & ~((state == RESP) && (gnt == PORT_I));

    arb_pick u_pick (
        .REQ0     (req0),
        .REQ1     (req1),
        .LAST_GNT (last_gnt),
        .WINNER   (pick_winner),
        .VALID    (pick_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last;

    // Remember the most recent grant; reset value makes port 0 win the first tie
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_last <= PORT_I;
        end else if ((state == IDLE) && pick_valid) begin
            rr_last <= pick_winner;
        end
    end

    assign last_gnt = rr_last;
`else
    assign last_gnt = PORT_I;
`endif

    // Route the winning requester's operation, address and data to the grant logic
    always_comb begin
        sel_write = P0_WRITE;
        sel_read  = P0_READ & ~P0_WRITE;
        sel_addr  = P0_ADDRESS;
        sel_wdata = P0_WRITEDATA;
        if (pick_winner == PORT_I) begin
            sel_write = P1_WRITE;
            sel_read  = P1_READ & ~P1_WRITE;
            sel_addr  = P1_ADDRESS;
            sel_wdata = P1_WRITEDATA;
        end
    end

    // Arbitration FSM with registered memory-side outputs and read-data capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            gnt           <= PORT_D;
            seen_busy     <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            P0_READDATA   <= '0;
            P1_READDATA   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt           <= pick_winner;
                        seen_busy     <= 1'b0;
                        MEM_READ      <= sel_read;
                        MEM_WRITE     <= sel_write;
                        MEM_ADDRESS   <= sel_addr;
                        MEM_WRITEDATA <= sel_wdata;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (MEM_BUSYWAIT) begin
                        seen_busy <= 1'b1;
                    end
                    if (seen_busy && !MEM_BUSYWAIT) begin
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        // A requester that withdrew mid-access gets no data update
                        if (MEM_READ && gnt_req) begin
                            if (gnt == PORT_I) begin
                                P1_READDATA <= MEM_READDATA;
                            end else begin
                                P0_READDATA <= MEM_READDATA;
                            end
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic from both requesters against a reference model.
module tb_mem_arbiter;

    logic        CLK;
    logic        RESET;
    logic        p_rd    [2];
    logic        p_wr    [2];
    logic [5:0]  p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] P0_READDATA;
    logic [31:0] P1_READDATA;
    logic        P0_BUSYWAIT;
    logic        P1_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mem_arbiter dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .P0_READ       (p_rd[0]),
        .P0_WRITE      (p_wr[0]),
        .P0_ADDRESS    (p_addr[0]),
        .P0_WRITEDATA  (p_wdata[0]),
        .P0_READDATA   (P0_READDATA),
        .P0_BUSYWAIT   (P0_BUSYWAIT),
        .P1_READ       (p_rd[1]),
        .P1_WRITE      (p_wr[1]),
        .P1_ADDRESS    (p_addr[1]),
        .P1_WRITEDATA  (p_wdata[1]),
        .P1_READDATA   (P1_READDATA),
        .P1_BUSYWAIT   (P1_BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bw(input int p);
        return (p == 1) ? P1_BUSYWAIT : P0_BUSYWAIT;
    endfunction

    function automatic logic [31:0] rdd(input int p);
        return (p == 1) ? P1_READDATA : P0_READDATA;
    endfunction

    function automatic logic [31:0] init_word(input int unsigned a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'hC0DE0000 + a * 32'h00010203;
    endfunction

    // Data memory model: busywait for mlat cycles from the request, write on completion
    logic [31:0] mem [64];
    int unsigned mcnt = 0;
    int unsigned mlat = 5;
    logic        mem_init;
    logic        rand_lat;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mcnt < mlat);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (MEM_READ | MEM_WRITE) begin
            if (mcnt < mlat) mcnt <= mcnt + 1;
            else if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
        if (!(MEM_READ | MEM_WRITE)) begin
            mcnt <= 0;
            mlat <= rand_lat ? $urandom_range(6, 1) : 5;
        end
    end

    // Scoreboard: one expected transaction per issued request, per port
    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q0 [$];
    txn_t        exp_q1 [$];
    logic [31:0] ref_mem [64];
    logic        sb_en;

    logic [1:0]  req_edge;
    logic        prev_act;
    logic        last_port;
    logic        cur_port;
    txn_t        cur;
    int unsigned act_cycles;
    logic [31:0] exp_rd [2];
    logic        mon_act;
    logic        mon_resp;
    logic [1:0]  mon_req;
    logic        exp_bw;

    always @(posedge CLK) req_edge <= {p_rd[1] | p_wr[1], p_rd[0] | p_wr[0]};

    // Monitor: predicts grant winner, memory op, latency, busywait and read data
    always @(negedge CLK) begin
        if (!sb_en) begin
            prev_act  = 1'b0;
            last_port = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            mon_act = MEM_READ | MEM_WRITE;
            mon_req = {p_rd[1] | p_wr[1], p_rd[0] | p_wr[0]};
            if (mon_act && !prev_act) begin
                checks++;
                if (req_edge == 2'b00) begin
                    failures++;
                    $display("FAIL grant_without_request: got grant expected none");
                end
                if (req_edge == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
                    cur_port = ~last_port;
`else
                    cur_port = 1'b0;
`endif
                end else begin
                    cur_port = req_edge[1];
                end
                last_port = cur_port;
                checks++;
                if ((cur_port ? exp_q1.size() : exp_q0.size()) == 0) begin
                    failures++;
                    $display("FAIL grant_port: got grant to port %0d expected none pending", cur_port);
                    cur = '0;
                end else begin
                    cur = cur_port ? exp_q1[0] : exp_q0[0];
                end
                check("grant_mem_write", {31'b0, MEM_WRITE}, {31'b0, cur.wr});
                check("grant_mem_read", {31'b0, MEM_READ}, {31'b0, ~cur.wr});
                act_cycles = 0;
            end
            if (mon_act) begin
                act_cycles++;
                check("mem_address", {26'b0, MEM_ADDRESS}, {26'b0, cur.addr});
                if (cur.wr) check("mem_writedata", MEM_WRITEDATA, cur.data);
            end
            mon_resp = !mon_act && prev_act;
            if (mon_resp) begin
                check("mem_latency", act_cycles, mlat + 1);
                if (cur_port) begin
                    if (exp_q1.size() > 0) void'(exp_q1.pop_front());
                end else begin
                    if (exp_q0.size() > 0) void'(exp_q0.pop_front());
                end
                if (cur.wr) check("mem_written", mem[cur.addr], cur.data);
                else exp_rd[cur_port] = cur.data;
            end
            for (int p = 0; p < 2; p++) begin
                exp_bw = mon_req[p] & ~(mon_resp && (cur_port == p[0]));
                check($sformatf("p%0d_busywait", p), {31'b0, bw(p)}, {31'b0, exp_bw});
                check($sformatf("p%0d_readdata", p), rdd(p), exp_rd[p]);
            end
            prev_act = mon_act;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic serve(input int p, input logic rd, input logic wr, input logic [5:0] a,
                         input logic [31:0] d, output logic [31:0] got, output int unsigned nact,
                         output int unsigned nlow, output logic fw, output logic fr,
                         output logic [5:0] fa);
        logic cap;
        logic done_now;
        cap = 1'b0; nact = 0; nlow = 0; got = '0; fw = 1'b0; fr = 1'b0; fa = '0;
        p_rd[p] = rd; p_wr[p] = wr; p_addr[p] = a; p_wdata[p] = d;
        for (int c = 0; c < 24; c++) begin
            @(negedge CLK);
            if (MEM_READ | MEM_WRITE) begin
                nact++;
                if (!cap) begin
                    cap = 1'b1; fw = MEM_WRITE; fr = MEM_READ; fa = MEM_ADDRESS;
                end
            end
            done_now = (p_rd[p] | p_wr[p]) && !bw(p);
            if (done_now) begin
                nlow++;
                got = rdd(p);
            end
            tick();
            if (done_now) begin
                p_rd[p] = 1'b0;
                p_wr[p] = 1'b0;
            end
        end
    endtask

    task automatic run_port(input int p, input int unsigned n);
        txn_t        t;
        int unsigned waitc;
        logic        both;
        for (int unsigned k = 0; k < n; k++) begin
            repeat ($urandom_range(3, 0)) @(posedge CLK);
            #1;
            both = 1'b0;
            if ((p == 0) && ($urandom_range(1, 0) == 1)) begin
                t.wr   = 1'b1;
                t.addr = 6'($urandom_range(31, 0));
                t.data = $urandom;
                both   = ($urandom_range(3, 0) == 0);
                ref_mem[t.addr] = t.data;
            end else begin
                t.wr   = 1'b0;
                t.addr = (p == 0) ? 6'($urandom_range(63, 0)) : 6'($urandom_range(63, 32));
                t.data = ref_mem[t.addr];
            end
            if (p == 0) exp_q0.push_back(t);
            else exp_q1.push_back(t);
            p_wr[p]    = t.wr;
            p_rd[p]    = ~t.wr | both;
            p_addr[p]  = t.addr;
            p_wdata[p] = t.wr ? t.data : $urandom;
            waitc = 0;
            do begin
                @(negedge CLK);
                waitc++;
            end while (bw(p) && (waitc < 100));
            check($sformatf("p%0d_served_in_time", p), {31'b0, bw(p)}, 32'd0);
            tick();
            p_rd[p] = 1'b0;
            p_wr[p] = 1'b0;
        end
    endtask

    logic [31:0] got;
    int unsigned nact;
    int unsigned nlow;
    logic        fw;
    logic        fr;
    logic [5:0]  fa;
    int          r0, r1, g1;
    logic [5:0]  g1_addr;
    logic [31:0] got1;
    logic        seq [$];

    initial begin
        RESET = 1'b1; mem_init = 1'b1; rand_lat = 1'b0; sb_en = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_rd[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        tick();
        tick();
        mem_init = 1'b0;
        RESET    = 1'b0;
        @(negedge CLK);
        check("reset_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("reset_mem_write", {31'b0, MEM_WRITE}, 32'd0);
        check("reset_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
        check("reset_mem_writedata", MEM_WRITEDATA, 32'd0);
        check("reset_p0_readdata", P0_READDATA, 32'd0);
        check("reset_p1_readdata", P1_READDATA, 32'd0);

        // Single dcache read with 5-cycle memory latency
        serve(0, 1'b1, 1'b0, 6'h05, 32'h0, got, nact, nlow, fw, fr, fa);
        check("read_mem_read_cycles", nact, 6);
        check("read_busywait_low_cycles", nlow, 1);
        check("read_p0_readdata", got, 32'hDEADBEEF);

        // Read and write together are a write
        serve(0, 1'b1, 1'b1, 6'h3F, 32'h0BADF00D, got, nact, nlow, fw, fr, fa);
        check("rw_mem_write", {31'b0, fw}, 32'd1);
        check("rw_mem_read", {31'b0, fr}, 32'd0);
        check("rw_mem_address", {26'b0, fa}, 32'h3F);
        check("rw_mem_content", mem[63], 32'h0BADF00D);
        check("rw_p0_readdata_kept", P0_READDATA, 32'hDEADBEEF);

        // Simultaneous dcache write and icache read
        p_wr[0] = 1'b1; p_addr[0] = 6'h0A; p_wdata[0] = 32'h12345678;
        p_rd[1] = 1'b1; p_addr[1] = 6'h01;
        r0 = -1; r1 = -1; g1 = -1; fw = 1'b0; fa = '0; g1_addr = '0; got1 = '0; nact = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if ((MEM_READ | MEM_WRITE) && (nact == 0)) begin
                nact = 1; fw = MEM_WRITE; fa = MEM_ADDRESS;
            end
            if (p_wr[0] && !P0_BUSYWAIT && (r0 < 0)) r0 = c;
            if (MEM_READ && (r0 >= 0) && (g1 < 0)) begin
                g1 = c; g1_addr = MEM_ADDRESS;
            end
            if (p_rd[1] && !P1_BUSYWAIT && (r1 < 0)) begin
                r1 = c; got1 = P1_READDATA;
            end
            tick();
            if (r0 == c) p_wr[0] = 1'b0;
            if (r1 == c) p_rd[1] = 1'b0;
        end
        check("tie_first_is_write", {31'b0, fw}, 32'd1);
        check("tie_first_address", {26'b0, fa}, 32'h0A);
        check("tie_p1_grant_after_resp", g1, r0 + 2);
        check("tie_p1_address", {26'b0, g1_addr}, 32'h01);
        check("tie_p1_resp_cycle", r1, g1 + 6);
        check("tie_p1_readdata", got1, init_word(1));
        check("tie_mem_content", mem[10], 32'h12345678);

        // Icache withdraws its read two cycles into the access
        p_rd[1] = 1'b1; p_addr[1] = 6'h21;
        nact = 0; nlow = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                nact++;
                if (MEM_ADDRESS != 6'h21) nlow++;
            end
            tick();
            if (nact == 2) p_rd[1] = 1'b0;
        end
        check("drop_mem_read_cycles", nact, 6);
        check("drop_address_changes", nlow, 0);
        check("drop_p1_readdata_kept", P1_READDATA, init_word(1));

        // Reset three cycles into an access abandons it; held request re-arbitrates
        p_rd[0] = 1'b1; p_addr[0] = 6'h05;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        check("idle_grants_next_request", {31'b0, MEM_READ}, 32'd1);
        tick();
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check("midreset_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("midreset_mem_write", {31'b0, MEM_WRITE}, 32'd0);
        check("midreset_mem_address", {26'b0, MEM_ADDRESS}, 32'd0);
        check("midreset_mem_writedata", MEM_WRITEDATA, 32'd0);
        check("midreset_p0_readdata", P0_READDATA, 32'd0);
        check("midreset_p1_readdata", P1_READDATA, 32'd0);
        serve(0, 1'b1, 1'b0, 6'h05, 32'h0, got, nact, nlow, fw, fr, fa);
        check("rearb_mem_read_cycles", nact, 6);
        check("rearb_p0_readdata", got, 32'hDEADBEEF);

        // Both ports requesting continuously
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        p_rd[0] = 1'b1; p_addr[0] = 6'h02;
        p_rd[1] = 1'b1; p_addr[1] = 6'h28;
        seq.delete();
        for (int c = 0; (c < 60) && (seq.size() < 4); c++) begin
            @(negedge CLK);
            if (!P0_BUSYWAIT) seq.push_back(1'b0);
            if (!P1_BUSYWAIT) seq.push_back(1'b1);
            tick();
        end
        p_rd[0] = 1'b0;
        p_rd[1] = 1'b0;
        check("contend_grant_count", seq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            logic exp_port;
`ifdef ARB_ROUND_ROBIN_EN
            exp_port = k[0];
`else
            exp_port = 1'b0;
`endif
            if (k < seq.size()) check($sformatf("contend_grant_%0d", k), {31'b0, seq[k]}, {31'b0, exp_port});
        end

        // Randomized traffic from both requesters
        repeat (3) tick();
        mem_init = 1'b1;
        RESET    = 1'b1;
        tick();
        tick();
        mem_init = 1'b0;
        RESET    = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        rand_lat = 1'b1;
        sb_en    = 1'b1;
        fork
            run_port(0, 40);
            run_port(1, 40);
        join
        repeat (4) tick();
        check("queue0_drained", exp_q0.size(), 0);
        check("queue1_drained", exp_q1.size(), 0);
        sb_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
